spike_mac_sequencer: RTL
========================

SPIKE_MAC_SEQUENCER -- requirements
Module: spike_mac_sequencer

Interface
REQ-001 SHALL take its parameters from DPE_params: INPUT_VEC_LEN=8, OUTPUT_VEC_LEN=8, WIDTH=8, OUT_WIDTH=11, ACC_WIDTH=24, STEP_W=16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cfg_wr  in  1  weight-row write strobe.
REQ-005 cfg_row  in  3  row index, 0..7.
REQ-006 cfg_data  in  8x8  eight WIDTH-bit weights for row cfg_row, columns 0..7.
REQ-007 cfg_err  out  1  one-cycle pulse when a write is rejected.
REQ-008 start  in  1  start-run pulse.
REQ-009 num_steps  in  STEP_W  timesteps in the run, sampled on start.
REQ-010 spk_valid / spk_ready  in / out  1 / 1  spike-vector handshake.
REQ-011 spk_data  in  INPUT_VEC_LEN  spike vector, bit i = row i.
REQ-012 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-013 res_data  out  8xACC_WIDTH  accumulated column sums.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DRAIN, DONE; reset state is IDLE.
REQ-016 Weight store (8x8xWIDTH registers) SHALL be written only in IDLE. A cfg_wr in any other state SHALL leave the store unchanged and pulse cfg_err on the next cycle.
REQ-017 In IDLE, start SHALL latch num_steps, clear all accumulators and the step counter, and go to RUN. If num_steps==0, the FSM SHALL instead go directly to DONE with res_data all zero.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 spk_ready SHALL be 1 only in RUN while step_cnt < num_steps. A vector transfers when spk_valid && spk_ready.
REQ-020 Pipeline per accepted vector:
  - cycle N: accept the vector.
  - cycle N+1: register the MAC column sums (OUT_WIDTH each) from the spike vector and the weight store.
  - cycle N+2: add the sums into the accumulators.
REQ-021 Accumulators SHALL zero-extend each OUT_WIDTH sum and saturate at 2^ACC_WIDTH-1; no wrap-around.
REQ-022 On acceptance of vector num_steps, the FSM SHALL go to DRAIN. DRAIN SHALL exit to DONE once the pipeline is empty, so res_valid first rises 2 cycles after the last acceptance.
REQ-023 Back-to-back acceptance SHALL sustain 1 vector/cycle with no bubbles. Gaps in spk_valid SHALL stall without corrupting the pipeline.
REQ-024 In DONE, res_valid=1 and res_data SHALL hold stable until res_valid && res_ready; then the FSM returns to IDLE on the next cycle.
REQ-025 res_ready asserted outside DONE SHALL have no effect. res_valid SHALL not depend combinationally on res_ready.
REQ-026 Weight store SHALL be static during a run; the weight-write ban in REQ-016 guarantees this.

Reset
REQ-027 On rst_n low, asynchronously and regardless of state, the block SHALL clear:
  - FSM to IDLE;
  - weight store, accumulators, pipeline registers, step_cnt and the latched num_steps;
  - outputs: busy=0, spk_ready=0, res_valid=0, cfg_err=0, res_data=0.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL abandon the run; no result SHALL be emitted after reset release.

Structure
REQ-029 DPE_params SHALL hold all width and length constants and the FSM state enum typedef.
REQ-030 The column-sum datapath SHALL be one instance of the existing spike_MAC_builtin.
REQ-031 Accumulator saturation SHALL be local logic; no other sub-modules.

Verification
REQ-032 Load identity weights (w[i][i]=1); start with num_steps=4; send spikes 8'hFF x4 back-to-back -> res_data[j]=4 for all j; res_valid 2 cycles after the 4th acceptance.
REQ-033 All weights 255; num_steps=65535; spikes 8'hFF every cycle -> each column = 2040*65535 = 133,691,400, which exceeds the max, so it saturates at 16,777,215.
REQ-034 cfg_wr during RUN -> cfg_err pulse one cycle later; result matches the pre-run weights.
REQ-035 num_steps=0 -> DONE with res_data all zero; spk_ready never asserts.
REQ-036 Hold res_ready=0 for 10 cycles in DONE -> res_data stable; handshake then returns to IDLE, busy=0.
REQ-037 Pull rst_n low mid-RUN after 2 of 5 vectors -> all outputs zero immediately; a new run afterwards (weights reloaded) is correct.

Source files
------------

// File: rtl/spike_mac_sequencer_pkg.sv
// Shared widths, vector lengths and FSM state encoding for the spike MAC sequencer.
package DPE_params;
  localparam int INPUT_VEC_LEN  = 8;
  localparam int OUTPUT_VEC_LEN = 8;
  localparam int WIDTH          = 8;
  localparam int OUT_WIDTH      = 11;
  localparam int ACC_WIDTH      = 24;
  localparam int STEP_W         = 16;
  localparam int ROW_W          = $clog2(INPUT_VEC_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/spike_mac_sequencer_mac.sv
// Combinational column sums: each column adds the weights of every row whose spike bit is set.
module spike_MAC_builtin
  import DPE_params::*;
(
  input  logic [INPUT_VEC_LEN-1:0]                             i_spikes,
  input  logic [INPUT_VEC_LEN-1:0][OUTPUT_VEC_LEN-1:0][WIDTH-1:0] i_weights,
  output logic [OUTPUT_VEC_LEN-1:0][OUT_WIDTH-1:0]             o_sums
);

  always_comb begin
    o_sums = '0;
    for (int j = 0; j < OUTPUT_VEC_LEN; j++) begin
      for (int i = 0; i < INPUT_VEC_LEN; i++) begin
        if (i_spikes[i]) begin
          o_sums[j] = o_sums[j] + OUT_WIDTH'(i_weights[i][j]);
        end
      end
    end
  end

endmodule

// File: rtl/spike_mac_sequencer.sv
// Runs num_steps spike vectors through the weight array and accumulates saturating column sums.
module spike_mac_sequencer
  import DPE_params::*;
(
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      cfg_wr,
  input  logic [ROW_W-1:0]                          cfg_row,
  input  logic [OUTPUT_VEC_LEN-1:0][WIDTH-1:0]      cfg_data,
  output logic                                      cfg_err,
  input  logic                                      start,
  input  logic [STEP_W-1:0]                         num_steps,
  input  logic                                      spk_valid,
  output logic                                      spk_ready,
  input  logic [INPUT_VEC_LEN-1:0]                  spk_data,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic [OUTPUT_VEC_LEN-1:0][ACC_WIDTH-1:0]  res_data,
  output logic                                      busy
);

  state_t r_state;
  state_t w_next;

  logic [INPUT_VEC_LEN-1:0][OUTPUT_VEC_LEN-1:0][WIDTH-1:0] r_weights;
  logic [STEP_W-1:0]                          r_num_steps;
  logic [STEP_W-1:0]                          r_step_cnt;
  logic [OUTPUT_VEC_LEN-1:0][OUT_WIDTH-1:0]   r_sums;
  logic                                       r_sum_vld;
  logic [OUTPUT_VEC_LEN-1:0][ACC_WIDTH-1:0]   r_acc;
  logic                                       r_cfg_err;

  logic [OUTPUT_VEC_LEN-1:0][OUT_WIDTH-1:0]   w_sums;
  logic [OUTPUT_VEC_LEN-1:0][ACC_WIDTH-1:0]   w_acc_next;
  logic [ACC_WIDTH:0]                         w_wide;
  logic                                       w_accept;
  logic                                       w_last;
  logic                                       w_start;

  assign spk_ready = (r_state == RUN) && (r_step_cnt < r_num_steps);
  assign w_accept  = spk_valid && spk_ready;
  assign w_last    = w_accept && (r_step_cnt == r_num_steps - STEP_W'(1));
  assign w_start   = start && (r_state == IDLE);

  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == DONE);
  assign res_data  = r_acc;
  assign cfg_err   = r_cfg_err;

  spike_MAC_builtin u_mac (
    .i_spikes  (spk_data),
    .i_weights (r_weights),
    .o_sums    (w_sums)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = (num_steps == '0) ? DONE : RUN;
      RUN:   if (w_last) w_next = DRAIN;
      // The single sum register retires on this edge, so DRAIN always lasts one cycle.
      DRAIN: w_next = DONE;
      DONE:  if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weights <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_wr && (r_state != IDLE);
      if (cfg_wr && (r_state == IDLE)) r_weights[cfg_row] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_steps <= '0;
      r_step_cnt  <= '0;
      r_sums      <= '0;
      r_sum_vld   <= 1'b0;
    end else begin
      r_sum_vld <= w_accept;
      if (w_accept) r_sums <= w_sums;
      if (w_start) begin
        r_num_steps <= num_steps;
        r_step_cnt  <= '0;
      end else if (w_accept) begin
        r_step_cnt  <= r_step_cnt + STEP_W'(1);
      end
    end
  end

  // One spare bit catches the carry; any carry pins the column at its maximum.
  always_comb begin
    w_acc_next = r_acc;
    w_wide     = '0;
    for (int j = 0; j < OUTPUT_VEC_LEN; j++) begin
      w_wide        = {1'b0, r_acc[j]} + (ACC_WIDTH + 1)'(r_sums[j]);
      w_acc_next[j] = w_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_wide[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_acc <= '0;
    else if (w_start)   r_acc <= '0;
    else if (r_sum_vld) r_acc <= w_acc_next;
  end

endmodule
